// File: rtl/store_narrow_unit_pkg.sv
// Shared definitions for the narrowing store path: size encodings, FSM states
// and the alignment rule used to reject illegal stores.
package store_narrow_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  // Size 11 is reserved and always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational little-endian lane merge: replaces the addressed byte/half of
// an existing word with the low bits of the store data.
module store_lane_merge
  import store_narrow_unit_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  // Select the lane(s) to overwrite; untouched lanes keep the old value.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          2'd3:    merged[31:24] = data[7:0];
          default: merged        = old_word;
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          merged[31:16] = data[15:0];
        end else begin
          merged[15:0] = data[15:0];
        end
      end
      SZ_WORD: merged = data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Multi-cycle store unit: narrows a register value to byte/half/word and writes
// it to a word-wide memory, using read-modify-write for sub-word stores.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  state_t            state;
  state_t            next_state;
  logic              accept;
  logic [DATA_W-1:0] st_data;
  logic [1:0]        st_size;
  logic [1:0]        st_lane;
  logic [DATA_W-1:0] merged;

  logic              n_ready;
  logic              n_done;
  logic              n_misalign;
  logic              n_mem_req;
  logic              n_mem_we;
  logic [ADDR_W-1:0] n_mem_addr;
  logic [DATA_W-1:0] n_mem_wdata;

  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .data     (st_data),
    .size     (st_size),
    .lane     (st_lane),
    .merged   (merged)
  );

  assign accept = req_valid & req_ready;

  // Next-state and address/data capture; mem_ack only matters in READ/WRITE,
  // the only states in which mem_req is high.
  always_comb begin
    next_state  = state;
    n_mem_addr  = mem_addr;
    n_mem_wdata = mem_wdata;
    case (state)
      IDLE: begin
        if (accept) begin
          n_mem_addr = {req_addr[ADDR_W-1:2], 2'b00};
          if (is_misaligned(req_size, req_addr[1:0])) begin
            next_state = FAULT;
          end else if (req_size == SZ_WORD) begin
            next_state  = WRITE;
            n_mem_wdata = req_data;
          end else begin
            next_state = READ;
          end
        end else begin
          next_state = IDLE;
        end
      end
      READ: begin
        if (mem_ack) begin
          next_state  = WRITE;
          n_mem_wdata = merged;
        end else begin
          next_state = READ;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          next_state = DONE;
        end else begin
          next_state = WRITE;
        end
      end
      DONE:    next_state = IDLE;
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they can be registered
  // alongside it and line up with the state they describe.
  always_comb begin
    n_ready    = 1'b0;
    n_done     = 1'b0;
    n_misalign = 1'b0;
    n_mem_req  = 1'b0;
    n_mem_we   = 1'b0;
    case (next_state)
      IDLE:  n_ready = 1'b1;
      READ:  n_mem_req = 1'b1;
      WRITE: begin
        n_mem_req = 1'b1;
        n_mem_we  = 1'b1;
      end
      DONE:  n_done = 1'b1;
      FAULT: begin
        n_done     = 1'b1;
        n_misalign = 1'b1;
      end
      default: n_ready = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      done      <= 1'b0;
      misalign  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else begin
      state     <= next_state;
      req_ready <= n_ready;
      done      <= n_done;
      misalign  <= n_misalign;
      mem_req   <= n_mem_req;
      mem_we    <= n_mem_we;
      mem_addr  <= n_mem_addr;
      mem_wdata <= n_mem_wdata;
    end
  end

  // Request fields held for the duration of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_data <= {DATA_W{1'b0}};
      st_size <= 2'b00;
      st_lane <= 2'b00;
    end else if (accept) begin
      st_data <= req_data;
      st_size <= req_size;
      st_lane <= req_addr[1:0];
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit with a cycle-driven memory responder
// and hand-computed expected values.
module tb_store_narrow_unit;
  import store_narrow_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        done;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_err = 0;

  int          r_done_cyc, r_reads, r_writes, r_gap, r_hold_err;
  logic        r_mis, r_ready_at_done, r_ready_after, r_finished;
  logic [31:0] r_wdata, r_waddr;

  always #5 clk = ~clk;

  store_narrow_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .done      (done),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one store, play memory with `waits` wait cycles per access, and record
  // what the DUT did. Cycle 1 is the first cycle after the accept edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                          input int waits, input logic [31:0] rd);
    int wc;
    bit started;
    r_done_cyc = -1; r_reads = 0; r_writes = 0; r_gap = 0; r_hold_err = 0;
    r_mis = 1'b0; r_ready_at_done = 1'b1; r_finished = 1'b0;
    r_wdata = 32'h0; r_waddr = 32'h0;
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = s; mem_rdata = rd;
    step;
    req_valid = 1'b0;
    wc = 0;
    started = 1'b0;
    for (int c = 1; c <= 60 && !r_finished; c++) begin
      if (done) begin
        r_done_cyc = c;
        r_mis = misalign;
        r_ready_at_done = req_ready;
        r_finished = 1'b1;
        mem_ack = 1'b0;
      end else begin
        if (mem_req) begin
          started = 1'b1;
          if (mem_we) begin
            if (r_writes == 0) begin
              r_wdata = mem_wdata;
              r_waddr = mem_addr;
            end else if (mem_wdata !== r_wdata || mem_addr !== r_waddr) begin
              r_hold_err++;
            end
            r_writes++;
          end else begin
            r_reads++;
          end
          if (wc == waits) begin
            mem_ack = 1'b1;
            wc = 0;
          end else begin
            mem_ack = 1'b0;
            wc++;
          end
        end else begin
          mem_ack = 1'b0;
          if (started) r_gap++;
        end
        step;
      end
    end
    check("done_seen", 32'(r_finished), 32'd1);
    step;
    r_ready_after = req_ready;
  endtask

  task automatic expect_ok(input string tag, input logic [31:0] waddr, input logic [31:0] wdata,
                           input int done_cyc, input int reads, input int writes);
    check({tag, "_done_cyc"}, 32'(r_done_cyc), 32'(done_cyc));
    check({tag, "_waddr"},    r_waddr, waddr);
    check({tag, "_wdata"},    r_wdata, wdata);
    check({tag, "_reads"},    32'(r_reads), 32'(reads));
    check({tag, "_writes"},   32'(r_writes), 32'(writes));
    check({tag, "_misalign"}, 32'(r_mis), 32'd0);
    check({tag, "_gap"},      32'(r_gap), 32'd0);
    check({tag, "_hold"},     32'(r_hold_err), 32'd0);
    check({tag, "_ready_at_done"}, 32'(r_ready_at_done), 32'd0);
    check({tag, "_ready_after"},   32'(r_ready_after), 32'd1);
  endtask

  task automatic expect_reject(input string tag);
    check({tag, "_done_cyc"}, 32'(r_done_cyc), 32'd1);
    check({tag, "_misalign"}, 32'(r_mis), 32'd1);
    check({tag, "_reads"},    32'(r_reads), 32'd0);
    check({tag, "_writes"},   32'(r_writes), 32'd0);
    check({tag, "_ready_after"}, 32'(r_ready_after), 32'd1);
  endtask

  initial begin
    int done_cnt;
    int wr_cnt;
    int first_ready;
    int done_cyc0;
    int done_cyc1;
    bit pending;
    logic [31:0] wa0, wa1, wd0, wd1;

    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_size = 2'b00;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    step; step;
    check("rst_ready",    32'(req_ready), 32'd1);
    check("rst_done",     32'(done), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_mem_req",  32'(mem_req), 32'd0);
    check("rst_mem_we",   32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    step;

    do_store(32'h0000_0100, 32'hDEAD_BEEF, SZ_WORD, 0, 32'h0);
    expect_ok("word", 32'h0000_0100, 32'hDEAD_BEEF, 2, 0, 1);

    do_store(32'h0000_0203, 32'h0000_00AB, SZ_BYTE, 0, 32'h1122_3344);
    expect_ok("byte3", 32'h0000_0200, 32'hAB22_3344, 3, 1, 1);

    do_store(32'h0000_0300, 32'h0000_0055, SZ_BYTE, 0, 32'h1122_3344);
    expect_ok("byte0", 32'h0000_0300, 32'h1122_3355, 3, 1, 1);

    do_store(32'h0000_0301, 32'hFFFF_FF66, SZ_BYTE, 1, 32'h1122_3344);
    expect_ok("byte1", 32'h0000_0300, 32'h1122_6644, 5, 2, 2);

    do_store(32'h0000_0202, 32'h0000_CAFE, SZ_HALF, 2, 32'h1122_3344);
    expect_ok("half_hi", 32'h0000_0200, 32'hCAFE_3344, 7, 3, 3);

    do_store(32'h0000_0204, 32'h1234_BEEF, SZ_HALF, 0, 32'h1122_3344);
    expect_ok("half_lo", 32'h0000_0204, 32'h1122_BEEF, 3, 1, 1);

    do_store(32'h0000_0201, 32'h0000_1111, SZ_HALF, 0, 32'h0);
    expect_reject("rej_half");
    do_store(32'h0000_0200, 32'h0000_2222, 2'b11, 0, 32'h0);
    expect_reject("rej_size11");
    do_store(32'h0000_0102, 32'h0000_3333, SZ_WORD, 0, 32'h0);
    expect_reject("rej_word");

    // Reset while a read is stalled.
    req_valid = 1'b1; req_addr = 32'h0000_0208; req_data = 32'h0000_7777; req_size = SZ_HALF;
    mem_ack = 1'b0;
    step;
    req_valid = 1'b0;
    step;
    check("mid_mem_req", 32'(mem_req), 32'd1);
    check("mid_mem_we",  32'(mem_we), 32'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_ready",   32'(req_ready), 32'd1);
    check("mid_rst_done",    32'(done), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (done || mem_req) done_cnt++;
    end
    check("mid_rst_quiet", 32'(done_cnt), 32'd0);
    do_store(32'h0000_0400, 32'h0102_0304, SZ_WORD, 0, 32'h0);
    expect_ok("post_rst", 32'h0000_0400, 32'h0102_0304, 2, 0, 1);

    // Spurious ack while idle.
    mem_ack = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (done || mem_req || !req_ready) done_cnt++;
    end
    mem_ack = 1'b0;
    check("idle_ack_ignored", 32'(done_cnt), 32'd0);

    // req_valid held high across a busy period: second request waits for ready.
    req_valid = 1'b1; req_addr = 32'h0000_0500; req_data = 32'hAAAA_0001; req_size = SZ_WORD;
    step;
    req_addr = 32'h0000_0600; req_data = 32'hBBBB_0002;
    done_cnt = 0; wr_cnt = 0; first_ready = -1; pending = 1'b0;
    done_cyc0 = -1; done_cyc1 = -1;
    wa0 = 32'h0; wa1 = 32'h0; wd0 = 32'h0; wd1 = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin
        if (done_cnt == 0) done_cyc0 = c; else done_cyc1 = c;
        done_cnt++;
      end
      if (mem_req && mem_we) begin
        if (wr_cnt == 0) begin wa0 = mem_addr; wd0 = mem_wdata; end
        else if (wr_cnt == 1) begin wa1 = mem_addr; wd1 = mem_wdata; end
        wr_cnt++;
      end
      if (req_ready && first_ready < 0) first_ready = c;
      if (pending) req_valid = 1'b0;
      if (req_valid && req_ready) pending = 1'b1;
      mem_ack = mem_req;
      step;
    end
    mem_ack = 1'b0;
    req_valid = 1'b0;
    check("b2b_first_ready", 32'(first_ready), 32'd3);
    check("b2b_done_cnt",    32'(done_cnt), 32'd2);
    check("b2b_done0",       32'(done_cyc0), 32'd2);
    check("b2b_done1",       32'(done_cyc1), 32'd5);
    check("b2b_writes",      32'(wr_cnt), 32'd2);
    check("b2b_waddr0",      wa0, 32'h0000_0500);
    check("b2b_wdata0",      wd0, 32'hAAAA_0001);
    check("b2b_waddr1",      wa1, 32'h0000_0600);
    check("b2b_wdata1",      wd1, 32'hBBBB_0002);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
